// File: rtl/jam_cost_table.sv
// -----------------------------------------------------------------------------
// jam_cost_table
//
// Cost-table responder for the job-assignment machine's W/J/Cost interface.
// The host loads an N x N table of cost entries over a valid/ready stream.
// After the load, the table answers Cost for any (W,J) in the same cycle.
// While serving, the block also counts completed permutation windows (W
// wrapping from N-1 back to 0). The host uses that count to cross-check the
// assignment engine's progress.
//
// Optional feature (compile-time macro JAM_COST_PERM_CHECK_EN):
//   Adds a sticky PERM_ERR output. PERM_ERR is set when the J values seen
//   during a completed window do not cover every job, i.e. they are not a
//   permutation. If the macro is undefined, the port and its logic do not
//   exist.
//
// Ports:
//   CLK          clock
//   RST          asynchronous, active-high reset
//   CLEAR        synchronous re-arm; returns to LOAD and clears status
//   LD_VALID     load beat valid
//   LD_READY     load beat accepted when LD_VALID && LD_READY
//   LD_DATA      cost entry, row-major (index = W*N + J)
//   LD_LAST      marks the final beat of the table
//   W, J         worker / job index from the assignment engine
//   Cost         table[W*N+J] while serving, else 0 (combinational)
//   TABLE_READY  table fully loaded and serving
//   LD_ERR       sticky load-framing error
//   PERM_CNT     completed W (N-1)->0 windows, saturating
//   PERM_ERR     (optional) sticky non-permutation window flag
// -----------------------------------------------------------------------------
module jam_cost_table #(
   parameter int N      = 8,
   parameter int COST_W = 7,
   parameter int PCNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLEAR,
   input  logic                 LD_VALID,
   output logic                 LD_READY,
   input  logic [COST_W-1:0]    LD_DATA,
   input  logic                 LD_LAST,
   input  logic [$clog2(N)-1:0] W,
   input  logic [$clog2(N)-1:0] J,
   output logic [COST_W-1:0]    Cost,
   output logic                 TABLE_READY,
   output logic                 LD_ERR,
`ifdef JAM_COST_PERM_CHECK_EN
   output logic [PCNT_W-1:0]    PERM_CNT,
   output logic                 PERM_ERR
`else
   output logic [PCNT_W-1:0]    PERM_CNT
`endif
);

   localparam int IDX_W = $clog2(N);
   localparam int PTR_W = 2 * IDX_W;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N * N - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SERVE = 2'd2;

   logic [1:0]        state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]  prev_W;
   logic [COST_W-1:0] table_mem [N*N];

   logic ld_fire;
   logic window_done;

   // CLEAR wins over a same-cycle beat, so the beat is neither written nor counted.
   assign ld_fire     = (state == LOAD) && LD_VALID && !CLEAR;
   assign window_done = (state == SERVE) && (prev_W == LAST_IDX) && (W == '0);
   assign LD_READY    = (state == LOAD);

   always_comb begin
      Cost = '0;
      if (state == SERVE)
         Cost = table_mem[{W, J}];
   end

   // NOTE: the table has no reset. A memory array with a reset cannot map
   // onto RAM. Cost is gated by SERVE, so stale contents are never visible
   // until a full reload has finished.
   always_ff @(posedge CLK) begin
      if (ld_fire)
         table_mem[wr_ptr] <= LD_DATA;
   end

   // NOTE: all state below uses non-blocking assignments. Every register
   // then samples pre-edge values, whatever order the statements are in.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         TABLE_READY <= 1'b0;
         LD_ERR      <= 1'b0;
         PERM_CNT    <= '0;
         prev_W      <= '0;
      end else begin
         prev_W <= W;
         if (CLEAR) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            TABLE_READY <= 1'b0;
            LD_ERR      <= 1'b0;
            PERM_CNT    <= '0;
         end else begin
            case (state)
               IDLE: state <= LOAD;
               LOAD: begin
                  if (ld_fire) begin
                     if (wr_ptr == LAST_PTR) begin
                        // Final slot written. Serve even if framing was
                        // wrong, but record the error.
                        state       <= SERVE;
                        TABLE_READY <= 1'b1;
                        wr_ptr      <= '0;
                        if (!LD_LAST)
                           LD_ERR <= 1'b1;
                     end else if (LD_LAST) begin
                        // Early LAST: restart framing from slot 0.
                        LD_ERR <= 1'b1;
                        wr_ptr <= '0;
                     end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                     end
                  end
               end
               SERVE: begin
                  if (window_done && (PERM_CNT != '1))
                     PERM_CNT <= PERM_CNT + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef JAM_COST_PERM_CHECK_EN
   logic [IDX_W-1:0] prev_J;
   logic [N-1:0]     job_mask;
   logic [N-1:0]     mask_full;

   // The job of the cycle that just ended is folded into the mask, so a
   // window check at the wrap also includes the last job.
   assign mask_full = job_mask | ({{(N-1){1'b0}}, 1'b1} << prev_J);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prev_J   <= '0;
         job_mask <= '0;
         PERM_ERR <= 1'b0;
      end else begin
         prev_J <= J;
         if (CLEAR) begin
            job_mask <= '0;
            PERM_ERR <= 1'b0;
         end else if (state == SERVE) begin
            if (window_done) begin
               if (mask_full != '1)
                  PERM_ERR <= 1'b1;
               job_mask <= '0;
            end else if (W != prev_W) begin
               job_mask <= mask_full;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// -----------------------------------------------------------------------------
// tb_jam_cost_table
//
// Self-checking bench for jam_cost_table. The stimulus is a linear series of
// directed steps with randomized data and indices. A behavioural model of the
// table contents, load framing, window count and (optionally) the
// permutation flag predicts every output.
// -----------------------------------------------------------------------------
module tb_jam_cost_table;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CLEAR;
   logic        LD_VALID;
   logic        LD_READY;
   logic [6:0]  LD_DATA;
   logic        LD_LAST;
   logic [2:0]  W;
   logic [2:0]  J;
   logic [6:0]  Cost;
   logic        TABLE_READY;
   logic        LD_ERR;
   logic [15:0] PERM_CNT;
`ifdef JAM_COST_PERM_CHECK_EN
   logic        PERM_ERR;
`endif

   jam_cost_table dut (
      .CLK         (CLK),
      .RST         (RST),
      .CLEAR       (CLEAR),
      .LD_VALID    (LD_VALID),
      .LD_READY    (LD_READY),
      .LD_DATA     (LD_DATA),
      .LD_LAST     (LD_LAST),
      .W           (W),
      .J           (J),
      .Cost        (Cost),
      .TABLE_READY (TABLE_READY),
      .LD_ERR      (LD_ERR),
`ifdef JAM_COST_PERM_CHECK_EN
      .PERM_CNT    (PERM_CNT),
      .PERM_ERR    (PERM_ERR)
`else
      .PERM_CNT    (PERM_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model.
   int       m_mem [64];
   bit       m_loading;
   bit       m_serving;
   bit       m_err;
   bit       m_perr;
   int       m_ptr;
   int       m_cnt;
   int       m_prev_w;
   int       m_prev_j;
   bit [7:0] m_mask;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0;
      m_serving = 0;
      m_err     = 0;
      m_perr    = 0;
      m_ptr     = 0;
      m_cnt     = 0;
      m_prev_w  = 0;
      m_prev_j  = 0;
      m_mask    = '0;
   endtask

   // One clock cycle. Drive inputs on the falling edge and check the
   // combinational outputs. Advance the model, then check the registered
   // outputs just after the rising edge.
   task automatic cycle(input bit c, input bit v, input int d, input bit l,
                        input int w, input int j);
      @(negedge CLK);
      CLEAR    = c;
      LD_VALID = v;
      LD_DATA  = d[6:0];
      LD_LAST  = l;
      W        = w[2:0];
      J        = j[2:0];
      #1;
      check("cost", Cost, m_serving ? m_mem[w*8+j] : 0);
      check("ld_ready", LD_READY, m_loading);

      if (c) begin
         m_loading = 1;
         m_serving = 0;
         m_ptr     = 0;
         m_err     = 0;
         m_cnt     = 0;
         m_mask    = '0;
         m_perr    = 0;
      end else if (!m_loading && !m_serving) begin
         m_loading = 1;
      end else if (m_loading) begin
         if (v) begin
            m_mem[m_ptr] = d;
            if (m_ptr == 63) begin
               m_loading = 0;
               m_serving = 1;
               m_ptr     = 0;
               if (!l) m_err = 1;
            end else if (l) begin
               m_err = 1;
               m_ptr = 0;
            end else begin
               m_ptr++;
            end
         end
      end else begin
         if (w != m_prev_w) m_mask[m_prev_j] = 1'b1;
         if (m_prev_w == 7 && w == 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_mask != 8'hFF) m_perr = 1;
            m_mask = '0;
         end
      end
      m_prev_w = w;
      m_prev_j = j;

      @(posedge CLK);
      #1;
      check("table_ready", TABLE_READY, m_serving);
      check("ld_err", LD_ERR, m_err);
      check("perm_cnt", PERM_CNT, m_cnt);
`ifdef JAM_COST_PERM_CHECK_EN
      check("perm_err", PERM_ERR, m_perr);
`endif
   endtask

   // Reset, then the one IDLE cycle, ending just after the edge that enters LOAD.
   task automatic do_reset();
      @(negedge CLK);
      RST      = 1;
      CLEAR    = 0;
      LD_VALID = 0;
      LD_LAST  = 0;
      LD_DATA  = '0;
      W        = '0;
      J        = '0;
      #1;
      model_reset();
      check("rst_cost", Cost, 0);
      check("rst_ld_ready", LD_READY, 0);
      check("rst_table_ready", TABLE_READY, 0);
      check("rst_ld_err", LD_ERR, 0);
      check("rst_perm_cnt", PERM_CNT, 0);
`ifdef JAM_COST_PERM_CHECK_EN
      check("rst_perm_err", PERM_ERR, 0);
`endif
      repeat (2) @(negedge CLK);
      RST = 0;
      #1;
      check("idle_ld_ready", LD_READY, 0);
      check("idle_cost", Cost, 0);
      @(posedge CLK);
      #1;
      m_loading = 1;
      check("idle_table_ready", TABLE_READY, 0);
   endtask

   // Send nbeats accepted beats. Data is the index (idx_data) or random.
   // LD_LAST goes on beat last_at. With toggle, every other cycle is idle.
   task automatic load_beats(input int nbeats, input bit idx_data,
                             input bit toggle, input int last_at);
      int beat = 0;
      int cyc  = 0;
      int d;
      while (beat < nbeats) begin
         if (toggle && (cyc % 2 == 1)) begin
            cycle(0, 0, $urandom_range(127), 0, 0, 0);
         end else begin
            d = idx_data ? beat : int'($urandom_range(127));
            cycle(0, 1, d, beat == last_at, 0, 0);
            beat++;
         end
         cyc++;
      end
   endtask

   task automatic hold_w0(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, $urandom_range(7));
   endtask

   task automatic sweep(input int js[8]);
      for (int w = 0; w < 8; w++) cycle(0, 0, 0, 0, w, js[w]);
      cycle(0, 0, 0, 0, 0, $urandom_range(7));
   endtask

   task automatic random_reads(input int n);
      for (int i = 0; i < n; i++)
         cycle(0, 0, 0, 0, $urandom_range(7), $urandom_range(7));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int js[8];
      for (int i = 0; i < 64; i++) m_mem[i] = 0;
      RST = 1; CLEAR = 0; LD_VALID = 0; LD_LAST = 0; LD_DATA = '0; W = '0; J = '0;

      // Reset, then an index-valued table with well-formed framing.
      do_reset();
      load_beats(64, 1, 0, 63);
      check("t1_ld_err", LD_ERR, 0);
      cycle(0, 0, 0, 0, 3, 5);
      check("t1_cost_3_5", Cost, 29);
      random_reads(20);

      // Reload with LD_VALID toggling every other cycle.
      cycle(1, 0, 0, 0, 0, 0);
      load_beats(64, 1, 1, 63);
      cycle(0, 0, 0, 0, 7, 7);
      check("t2_cost_7_7", Cost, 63);
      cycle(0, 0, 0, 0, 0, 0);
      check("t2_cost_0_0", Cost, 0);

      // Early LD_LAST on beat 10, then a full reload.
      cycle(1, 0, 0, 0, 0, 0);
      load_beats(11, 0, 0, 10);
      check("t3_ld_err_early", LD_ERR, 1);
      check("t3_still_load", LD_READY, 1);
      load_beats(64, 0, 0, 63);
      check("t3_ld_err_kept", LD_ERR, 1);
      check("t3_serving", TABLE_READY, 1);
      random_reads(30);
      cycle(1, 0, 0, 0, 0, 0);
      check("t3_ld_err_clear", LD_ERR, 0);

      // Three sweeps with W held at 0 in between.
      load_beats(64, 0, 0, 63);
      hold_w0(5);
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 8; k++) js[k] = $urandom_range(7);
         sweep(js);
         hold_w0(5);
      end
      check("t4_perm_cnt", PERM_CNT, 3);

      // CLEAR together with a beat at wr_ptr 20 drops the beat.
      cycle(1, 0, 0, 0, 0, 0);
      check("t5_cnt_cleared", PERM_CNT, 0);
      load_beats(20, 0, 0, -1);
      cycle(1, 1, $urandom_range(127), 0, 0, 0);
      check("t5_table_ready", TABLE_READY, 0);
      load_beats(64, 0, 0, 63);
      for (int i = 0; i < 64; i++) cycle(0, 0, 0, 0, i / 8, i % 8);

      // Reset while serving: Cost drops at once and stays 0 until a reload.
      do_reset();
      random_reads(4);
      load_beats(64, 0, 0, 63);
      hold_w0(3);

      // Permutation checks: a reversed sweep, then one with a repeated job.
      js = '{7, 6, 5, 4, 3, 2, 1, 0};
      sweep(js);
`ifdef JAM_COST_PERM_CHECK_EN
      check("t6_perm_ok", PERM_ERR, 0);
`endif
      hold_w0(2);
      js = '{0, 1, 2, 3, 4, 5, 6, 6};
      sweep(js);
`ifdef JAM_COST_PERM_CHECK_EN
      check("t6_perm_bad", PERM_ERR, 1);
`endif
      check("t6_perm_cnt", PERM_CNT, 2);

      // Random rounds: reload, random reads and random sweeps.
      for (int r = 0; r < 3; r++) begin
         cycle(1, 0, 0, 0, 0, 0);
         load_beats(64, 0, ($urandom_range(1) == 1), 63);
         random_reads(25);
         for (int k = 0; k < 8; k++) js[k] = $urandom_range(7);
         sweep(js);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Cost-table responder on the far end of the job-assignment machine's W/J/Cost interface.
- Loaded once over a valid/ready stream with an 8x8 table of 7-bit worker/job costs, then serves Cost for any (W,J) with zero latency.
- Counts completed permutation windows, i.e. W sweeps 0..7, so the host can cross-check the assignment engine's progress.

Parameters:
- N, 8: workers = jobs; table depth N*N = 64 (W and J are 3 bits wide).
- COST_W, 7: cost entry width.
- PCNT_W, 16: permutation-window counter width (8! = 40320 fits).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- CLEAR  in  1  synchronous re-arm; return to LOAD.
- LD_VALID  in  1  load beat valid.
- LD_READY  out  1  load beat accepted when LD_VALID&&LD_READY.
- LD_DATA  in  COST_W  cost entry, row-major order, index = W*8+J.
- LD_LAST  in  1  marks the final (64th) beat.
- W  in  3  worker index from the assignment engine.
- J  in  3  job index from the assignment engine.
- Cost  out  COST_W  table[W*8+J], combinational.
- TABLE_READY  out  1  table fully loaded; serving.
- LD_ERR  out  1  sticky load-framing error.
- PERM_CNT  out  PCNT_W  completed W 7->0 windows, saturating.

Behaviour:
- Reset values:
  - state=IDLE; wr_ptr=0; LD_READY=0; TABLE_READY=0; LD_ERR=0; PERM_CNT=0.
  - prev_W=0; Cost=0. Table contents are not reset.
- FSM states: IDLE, LOAD, SERVE.
- IDLE:
  - Lasts exactly one cycle.
  - Unconditionally goes to LOAD.
- LOAD:
  - LD_READY=1.
  - Accepted beat: table[wr_ptr]<=LD_DATA, wr_ptr<=wr_ptr+1 (6-bit).
  - Accept at wr_ptr==63: go to SERVE and wr_ptr wraps to 0. If LD_LAST==0 on that beat, set LD_ERR but still enter SERVE.
  - Accept with LD_LAST==1 at wr_ptr<63: set LD_ERR, write the beat, force wr_ptr<=0, stay in LOAD (restart framing).
- SERVE:
  - LD_READY=0; TABLE_READY=1 (registered; high from the first SERVE cycle).
  - LD_VALID is ignored.
- Cost:
  - Combinational: table[{W,J}] while in SERVE, 0 otherwise.
  - Zero cycle latency; the assignment engine accumulates Cost in the same cycle it drives W/J.
- Window counting:
  - prev_W registered every cycle.
  - In SERVE, a cycle with prev_W==7 and W==0 increments PERM_CNT.
  - PERM_CNT saturates at all-ones.
  - W holding at 0 across several cycles does not count.
- CLEAR:
  - Highest priority over all other activity, including a same-cycle load beat, which is dropped.
  - Next state LOAD, wr_ptr=0, TABLE_READY=0, LD_ERR=0, PERM_CNT=0.
  - Table contents are kept until overwritten.
- RST mid-load or mid-serve: immediate return to IDLE. A full reload is required before Cost is nonzero again.

Optional Feature:
- Macro: JAM_COST_PERM_CHECK_EN.
- Enabled: adds output PERM_ERR (1 bit, sticky, reset 0, cleared by CLEAR) plus an internal 8-bit job mask and prev_J register. Operates in SERVE only:
  - prev_J is registered every cycle.
  - On each cycle with W!=prev_W: mask[prev_J]<=1.
  - On a 7->0 transition, the completed mask including the final bit is checked. If it is not 8'hFF, set PERM_ERR; then clear the mask.
  - Together this flags a window where the engine's J sequence is not a permutation.
- Disabled: no PERM_ERR port and no mask/prev_J logic.

Test Plan:
- Load table[i]=i (beats 0..63, LD_LAST on beat 63) -> LD_ERR=0. TABLE_READY rises the cycle after beat 63. W=3,J=5 gives Cost=29 in the same cycle.
- Load with LD_VALID toggling every other cycle -> LD_READY stays 1, exactly 64 writes. W=7,J=7 gives Cost=63; W=0,J=0 gives Cost=0.
- LD_LAST on beat 10 -> LD_ERR=1, state stays LOAD. A full 64-beat reload then reaches SERVE with LD_ERR still 1. CLEAR clears LD_ERR.
- In SERVE, drive W 0..7 then 0, three times, with W held at 0 for 5 cycles between sweeps -> PERM_CNT=3.
- CLEAR asserted in the same cycle as an LD_VALID beat during LOAD at wr_ptr=20 -> beat dropped, wr_ptr=0, PERM_CNT=0, TABLE_READY=0. RST mid-SERVE -> Cost=0 next cycle.
- With JAM_COST_PERM_CHECK_EN: sweep J=7,6,5,4,3,2,1,0 -> PERM_ERR=0. Sweep J=0,1,2,3,4,5,6,6 -> PERM_ERR=1 after the 7->0 transition.
